// File: rtl/bsa_pkg.sv
// bsa_pkg: shared state encoding and counter sizing for the bit-serial adder.
package bsa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int CNT_W(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bit_serial_adder_full_adder_cell.sv
// full_adder_cell: combinational 1-bit full adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial add of two WIDTH-bit operands through one full-adder cell.
module bit_serial_adder
    import bsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = CNT_W(WIDTH);

    state_t           state, next;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
    logic [CW-1:0]    cnt;
    logic             carry, fa_sum, fa_cout, last;

    full_adder_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .sum (fa_sum),
        .cout(fa_cout)
    );

    assign last = cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    // Encoding 2'd3 is unreachable; the default arm sends it back to IDLE.
    always_comb begin
        next = IDLE;
        case (state)
            IDLE:    next = in_valid  ? SHIFT : IDLE;
            SHIFT:   next = last      ? DONE  : SHIFT;
            DONE:    next = out_ready ? IDLE  : DONE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (state == IDLE && in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            carry  <= cin;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
            carry  <= fa_cout;
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            cnt    <= last ? cnt : cnt + 1'b1;
        end
    end

    assign sum  = sum_sr;
    assign cout = carry;

endmodule
